// File: rtl/cascade_down_counter_pkg.sv
// Shared definitions for the cascaded timer counter.
//   state_t : run-control FSM states (IDLE, RUN, DONE)
//   DIG_W   : width of one BCD/modulo digit
package cascade_down_counter_pkg;

  localparam int unsigned DIG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cascade_down_counter_if.sv
// Control/status bundle between the timer counter and its neighbours.
//   master : drives tick, load, load_val, start, stop, up; reads q and flags
//   slave  : the counter; reads controls, drives q, running, expired, done, ovf
import cascade_down_counter_pkg::*;

interface cascade_down_counter_if #(
  parameter int unsigned NDIG = 4
);
  logic                    tick;
  logic                    load;
  logic [DIG_W*NDIG-1:0]   load_val;
  logic                    start;
  logic                    stop;
  logic                    up;
  logic [DIG_W*NDIG-1:0]   q;
  logic                    running;
  logic                    expired;
  logic                    done;
  logic                    ovf;

  modport master (
    output tick, load, load_val, start, stop, up,
    input  q, running, expired, done, ovf
  );

  modport slave (
    input  tick, load, load_val, start, stop, up,
    output q, running, expired, done, ovf
  );
endinterface

// File: rtl/cascade_down_counter_timer_digit.sv
// One 4-bit modulo-(MAX+1) digit of the cascaded timer.
//   clk, reset : clock, asynchronous active-high reset (q -> 0)
//   en         : count enable for this cycle
//   up         : 1 increment, 0 decrement
//   cin        : carry (up) / borrow (down) from the lower digits
//   cout       : carry/borrow to the next digit
//   ld, ld_val : synchronous load, value clamped to MAX
//   q          : digit value
import cascade_down_counter_pkg::*;

module timer_digit #(
  parameter logic [DIG_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             cin,
  output logic             cout,
  input  logic             ld,
  input  logic [DIG_W-1:0] ld_val,
  output logic [DIG_W-1:0] q
);

  // Ripple term: this digit passes the carry/borrow on only when it is
  // itself about to wrap.
  assign cout = cin && (up ? (q == MAX) : (q == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= (ld_val > MAX) ? MAX : ld_val;
    end else if (en && cin) begin
      if (up) q <= (q == MAX) ? '0  : q + 4'd1;
      else    q <= (q == '0)  ? MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/cascade_down_counter.sv
// Multi-digit BCD/modulo timer with run control.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : slave side of cascade_down_counter_if
//           (tick/load/load_val/start/stop/up in; q/running/expired/done/ovf out)
// NDIG digits, digit i limited to DIGMAX[4i+3:4i]. Counts on tick while RUN,
// stops in DONE when a down count reaches zero, pulses ovf on up-count wrap.
import cascade_down_counter_pkg::*;

module cascade_down_counter #(
  parameter int unsigned             NDIG   = 4,
  parameter logic [DIG_W*NDIG-1:0]   DIGMAX = 16'h5959
) (
  input  logic                  clk,
  input  logic                  reset,
  cascade_down_counter_if.slave bus
);

  localparam int unsigned W = DIG_W * NDIG;

  state_t          state;
  logic            mode_up;
  logic            running_r;
  logic            expired_r;
  logic            done_r;
  logic            ovf_r;
  logic [W-1:0]    q_int;
  logic [NDIG:0]   chain;
  logic            step;
  logic            expire_now;
  logic            wrap_now;

  // A tick counts only in RUN and only when neither load nor stop wins.
  assign step     = (state == ST_RUN) && bus.tick && !bus.load && !bus.stop;
  assign chain[0] = 1'b1;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    timer_digit #(
      .MAX(DIGMAX[DIG_W*i +: DIG_W])
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .en     (step),
      .up     (mode_up),
      .cin    (chain[i]),
      .cout   (chain[i+1]),
      .ld     (bus.load),
      .ld_val (bus.load_val[DIG_W*i +: DIG_W]),
      .q      (q_int[DIG_W*i +: DIG_W])
    );
  end

  // A down tick reaches all-zero only from q == 1: any other nonzero value
  // either leaves digit 0 nonzero or wraps it to its maximum.
  assign expire_now = step && !mode_up && (q_int == W'(1));
  assign wrap_now   = step &&  mode_up && chain[NDIG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_up   <= 1'b0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      if (bus.load) begin
        state     <= ST_IDLE;
        running_r <= 1'b0;
        expired_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!bus.stop && bus.start && (bus.up || q_int != '0)) begin
              state     <= ST_RUN;
              mode_up   <= bus.up;
              running_r <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.stop) begin
              state     <= ST_IDLE;
              running_r <= 1'b0;
            end else if (expire_now) begin
              state     <= ST_DONE;
              running_r <= 1'b0;
              expired_r <= 1'b1;
              done_r    <= 1'b1;
            end else if (wrap_now) begin
              ovf_r <= 1'b1;
            end
          end
          ST_DONE: ;
          default: begin
            state     <= ST_IDLE;
            running_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q       = q_int;
  assign bus.running = running_r;
  assign bus.expired = expired_r;
  assign bus.done    = done_r;
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_cascade_down_counter.sv
// Directed self-checking bench for cascade_down_counter (NDIG=4, MM:SS limits).
module tb_cascade_down_counter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cascade_down_counter_if #(.NDIG(4)) bus ();

  cascade_down_counter #(
    .NDIG   (4),
    .DIGMAX (16'h5959)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1; bus.load_val = v;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic do_start(input logic u);
    bus.start = 1'b1; bus.up = u;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tick = 0; bus.load = 0; bus.load_val = '0;
    bus.start = 0; bus.stop = 0; bus.up = 0;
    cyc(); cyc();
    checks++;
    if (bus.q !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h expected 0000", bus.q); end
    checks++;
    if ({bus.running, bus.expired, bus.done, bus.ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.running, bus.expired, bus.done, bus.ovf});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_down_borrow();
    do_load(16'h0130);
    checks++;
    if (bus.q !== 16'h0130) begin errors++; $display("FAIL load_0130: got %h expected 0130", bus.q); end
    do_start(1'b0);
    checks++;
    if (bus.running !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", bus.running); end
    do_tick();
    checks++;
    if (bus.q !== 16'h0129) begin errors++; $display("FAIL down_0129: got %h expected 0129", bus.q); end
    for (int i = 0; i < 29; i++) do_tick();
    checks++;
    if (bus.q !== 16'h0100) begin errors++; $display("FAIL down_0100: got %h expected 0100", bus.q); end
    do_tick();
    checks++;
    if (bus.q !== 16'h0059) begin errors++; $display("FAIL down_wrap_0059: got %h expected 0059", bus.q); end
    checks++;
    if ({bus.running, bus.done} !== 2'b10) begin
      errors++; $display("FAIL down_flags: got %b expected 10", {bus.running, bus.done});
    end
  endtask

  task automatic test_expire();
    do_load(16'h0001);
    do_start(1'b0);
    do_tick();
    checks++;
    if (bus.q !== 16'h0000) begin errors++; $display("FAIL expire_q: got %h expected 0000", bus.q); end
    checks++;
    if ({bus.done, bus.expired, bus.running} !== 3'b110) begin
      errors++; $display("FAIL expire_flags: got %b expected 110", {bus.done, bus.expired, bus.running});
    end
    cyc();
    checks++;
    if ({bus.done, bus.expired} !== 2'b01) begin
      errors++; $display("FAIL done_one_cycle: got %b expected 01", {bus.done, bus.expired});
    end
    bus.tick = 1'b1; bus.start = 1'b1;
    cyc(); cyc();
    bus.tick = 1'b0; bus.start = 1'b0;
    checks++;
    if ({bus.q, bus.expired, bus.running, bus.done} !== {16'h0000, 3'b100}) begin
      errors++; $display("FAIL done_hold: got %h/%b expected 0000/100", bus.q, {bus.expired, bus.running, bus.done});
    end
    do_load(16'h0010);
    checks++;
    if ({bus.q, bus.expired} !== {16'h0010, 1'b0}) begin
      errors++; $display("FAIL done_load: got %h/%b expected 0010/0", bus.q, bus.expired);
    end
  endtask

  task automatic test_up_ovf();
    do_load(16'h5958);
    do_start(1'b1);
    do_tick();
    checks++;
    if ({bus.q, bus.ovf} !== {16'h5959, 1'b0}) begin
      errors++; $display("FAIL up_5959: got %h/%b expected 5959/0", bus.q, bus.ovf);
    end
    do_tick();
    checks++;
    if ({bus.q, bus.ovf, bus.running} !== {16'h0000, 2'b11}) begin
      errors++; $display("FAIL up_wrap: got %h/%b expected 0000/11", bus.q, {bus.ovf, bus.running});
    end
    cyc();
    checks++;
    if ({bus.ovf, bus.running} !== 2'b01) begin
      errors++; $display("FAIL ovf_one_cycle: got %b expected 01", {bus.ovf, bus.running});
    end
    // Direction input changes mid-run must not alter the latched mode.
    bus.up = 1'b0;
    do_tick();
    checks++;
    if (bus.q !== 16'h0001) begin errors++; $display("FAIL mode_latched: got %h expected 0001", bus.q); end
  endtask

  task automatic test_clamp();
    do_load(16'h9999);
    checks++;
    if (bus.q !== 16'h5959) begin errors++; $display("FAIL clamp_9999: got %h expected 5959", bus.q); end
    do_load(16'h1A7F);
    checks++;
    if (bus.q !== 16'h1959) begin errors++; $display("FAIL clamp_1A7F: got %h expected 1959", bus.q); end
    do_load(16'h0000);
    do_start(1'b0);
    checks++;
    if (bus.running !== 1'b0) begin errors++; $display("FAIL zero_start: got %b expected 0", bus.running); end
    do_start(1'b1);
    checks++;
    if (bus.running !== 1'b1) begin errors++; $display("FAIL zero_start_up: got %b expected 1", bus.running); end
  endtask

  task automatic test_stop_tick();
    do_load(16'h0200);
    do_start(1'b0);
    bus.stop = 1'b1; bus.tick = 1'b1;
    cyc();
    bus.stop = 1'b0; bus.tick = 1'b0;
    checks++;
    if ({bus.q, bus.running} !== {16'h0200, 1'b0}) begin
      errors++; $display("FAIL stop_tick: got %h/%b expected 0200/0", bus.q, bus.running);
    end
    do_tick();
    checks++;
    if (bus.q !== 16'h0200) begin errors++; $display("FAIL idle_tick: got %h expected 0200", bus.q); end
    do_start(1'b0);
    do_tick();
    checks++;
    if (bus.q !== 16'h0159) begin errors++; $display("FAIL resume_0159: got %h expected 0159", bus.q); end
    bus.load = 1'b1; bus.load_val = 16'h0345; bus.start = 1'b1;
    cyc();
    bus.load = 1'b0; bus.start = 1'b0;
    checks++;
    if ({bus.q, bus.running} !== {16'h0345, 1'b0}) begin
      errors++; $display("FAIL load_start: got %h/%b expected 0345/0", bus.q, bus.running);
    end
  endtask

  task automatic test_reset_mid();
    do_load(16'h0002);
    do_start(1'b0);
    do_tick();
    bus.tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.q, bus.running, bus.expired, bus.done, bus.ovf} !== {16'h0000, 4'b0000}) begin
      errors++; $display("FAIL reset_async: got %h/%b expected 0000/0000", bus.q,
                         {bus.running, bus.expired, bus.done, bus.ovf});
    end
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    bus.tick = 1'b0;
    checks++;
    if ({bus.q, bus.running, bus.expired, bus.done, bus.ovf} !== {16'h0000, 4'b0000}) begin
      errors++; $display("FAIL reset_release: got %h/%b expected 0000/0000", bus.q,
                         {bus.running, bus.expired, bus.done, bus.ovf});
    end
  endtask

  initial begin
    test_reset();
    test_down_borrow();
    test_expire();
    test_up_ovf();
    test_clamp();
    test_stop_tick();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cascade_down_counter.md
# cascade_down_counter

Parametrised multi-digit BCD/modulo timer counter replacing hand-chained single-digit down counters in the kitchen-timer path. It holds NDIG 4-bit digits, each with its own maximum value, and counts down or up on a one-cycle tick strobe. A small run-control FSM adds load, start, stop, expiry detection and wrap reporting. It sits between the prescaler (tick source) and the seven-segment display driver.

## Interface
- NDIG, 4: number of 4-bit digits.
- DIGMAX, 16'h5959: per-digit maximum; digit i limit in bits [4i+3:4i], each 1..15; width 4*NDIG (default MM:SS).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick  in  1  count strobe, one clk cycle wide.
- load  in  1  load load_val and enter IDLE.
- load_val  in  4*NDIG  preset value, digit-packed.
- start  in  1  begin counting.
- stop  in  1  pause counting.
- up  in  1  direction: 1 up, 0 down; sampled on accepted start only.
- q  out  4*NDIG  current count, digit-packed.
- running  out  1  high in RUN.
- expired  out  1  high in DONE.
- done  out  1  one-cycle pulse on expiry.
- ovf  out  1  one-cycle pulse on up-count wrap.

## Operation
- Reset: q=0, state IDLE, internal mode=down, running=expired=done=ovf=0.
- States: IDLE, RUN, DONE.
- IDLE: start with (up=1 or q!=0) -> RUN, mode latched from up; start with up=0 and q==0 ignored.
- RUN: stop -> IDLE (pause, q held); tick counts per mode; other inputs ignored except load.
- DONE: start ignored; load -> IDLE; q held at 0.
- load in any state: each digit of q = min(load_val digit, DIGMAX digit); state -> IDLE.
- Priority in one cycle: load > stop > tick > start.
- Down count: digit 0 decrements; digit i borrows when all lower digits are 0; a digit at 0 with borrow-in wraps to its DIGMAX. Tick that makes q all-zero -> DONE, done pulse.
- Up count: digit 0 increments; carry when all lower digits at their DIGMAX; digit at DIGMAX with carry-in wraps to 0. Tick with all digits at max -> q=0, ovf pulse, stays RUN.
- tick outside RUN: no effect.
- up changes during RUN: no effect until next accepted start.

## Timing
- All outputs registered; no combinational input-to-output path.
- q updates on the clk edge sampling tick in RUN; latency 1 cycle.
- done and ovf assert on the same edge q updates and last exactly one cycle.
- expired rises with done and holds until load or reset.
- running reflects state after each edge; start-to-running latency 1 cycle.
- load: q valid 1 cycle after load asserted.
- reset mid-count: immediate asynchronous return to reset values; no done/ovf pulse.

## Structure
- Shared package: state encoding (IDLE/RUN/DONE) and digit-width constant (4).
- One sub-module, timer_digit: single 4-bit digit with max parameter, up/down select, enable, carry/borrow in, carry/borrow out, synchronous load with clamp; NDIG instances in a generate loop, chain through carry/borrow.
- Top level holds the FSM, mode register, and done/ovf pulse registers.

## Test plan
- Load 16'h0130, up=0, start, tick x1 -> q=16'h0129; continue to q=16'h0100, one tick -> q=16'h0059 (tens-of-seconds wraps to 5).
- Load 16'h0001, start, tick -> q=16'h0000, done high exactly one cycle, expired=1, running=0; further ticks and start leave q=0 and state DONE.
- Load 16'h5958, up=1, start, two ticks -> q=16'h5959, then q=16'h0000 with ovf one cycle, running stays 1.
- Load 16'h9999 -> q=16'h5959 (per-digit clamp); load 16'h0000 with up=0 then start -> stays IDLE, running=0.
- In RUN at 16'h0200 assert stop and tick same cycle -> q stays 16'h0200, state IDLE; load and start same cycle -> q loaded, state IDLE.
- Reset asserted mid-RUN between clk edges -> q=0, all flags 0 immediately, no done/ovf pulse after release.
